// File: rtl/cic_pkg.sv
// Shared CIC constants and helpers, common to the interpolator and decimator.
package cic_pkg;

    localparam int CIC_WIDTH    = 41;
    localparam int CIC_ORDER    = 5;
    localparam int CIC_SAMPLE_W = 8;
    localparam int CIC_RATIO_W  = 16;
    localparam int CIC_SHIFT_W  = 6;

    typedef logic signed [CIC_SAMPLE_W-1:0] cic_sample_t;

    // Ratios of 0 and 1 both mean "every cycle"; the phase counter then stays at 0.
    function automatic logic [CIC_RATIO_W-1:0] cic_ratio_eff(input logic [CIC_RATIO_W-1:0] r);
        return (r < CIC_RATIO_W'(2)) ? CIC_RATIO_W'(1) : r;
    endfunction

endpackage

// File: rtl/cic_sat.sv
// Arithmetic right shift of a wide CIC accumulator followed by clamping to
// the signed sample range.
module cic_sat
    import cic_pkg::*;
#(
    parameter int WIDTH = CIC_WIDTH
) (
    input  logic [WIDTH-1:0]        din,
    input  logic [CIC_SHIFT_W-1:0]  shift,
    output logic [CIC_SAMPLE_W-1:0] dout
);

    localparam logic signed [WIDTH-1:0] SAT_MAX =
        {{(WIDTH-CIC_SAMPLE_W+1){1'b0}}, {(CIC_SAMPLE_W-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN =
        {{(WIDTH-CIC_SAMPLE_W+1){1'b1}}, {(CIC_SAMPLE_W-1){1'b0}}};

    logic signed [WIDTH-1:0] shifted;

    always_comb begin
        shifted = $signed(din) >>> shift;
        if (shifted > SAT_MAX) begin
            dout = SAT_MAX[CIC_SAMPLE_W-1:0];
        end else if (shifted < SAT_MIN) begin
            dout = SAT_MIN[CIC_SAMPLE_W-1:0];
        end else begin
            dout = shifted[CIC_SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator: low-rate comb cascade, zero-stuffing, high-rate integrator
// cascade, then shift-and-saturate to 8 bits. One output per clk.
module cic_interp
    import cic_pkg::*;
#(
    parameter int WIDTH = CIC_WIDTH,
    parameter int ORDER = CIC_ORDER
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CIC_RATIO_W-1:0]  interp_ratio,
    input  logic [CIC_SHIFT_W-1:0]  out_shift,
    input  logic [CIC_SAMPLE_W-1:0] d_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CIC_SAMPLE_W-1:0] d_out,
    output logic                    out_valid,
    output logic                    underrun
);

    logic [CIC_RATIO_W-1:0]   phase_q, phase_d;
    logic [CIC_RATIO_W-1:0]   ratio_q, ratio_d;
    logic [CIC_RATIO_W-1:0]   r_cur, r_eff;
    logic                     consume;
    logic [CIC_SAMPLE_W-1:0]  sample;
    logic [WIDTH-1:0]         sample_ext;
    logic [WIDTH-1:0]         comb_out_q, comb_out_d;
    logic                     stuff_q, stuff_d;
    logic [WIDTH-1:0]         integ_in;
    logic [ORDER-1:0][WIDTH-1:0] integ_q, integ_d;
    logic [ORDER+1:0]         vld_pipe_q, vld_pipe_d;
    logic [CIC_SAMPLE_W-1:0]  sat_out;
    logic [CIC_SAMPLE_W-1:0]  d_out_q, d_out_d;

    // Phase 0 uses the live ratio so a new R takes effect exactly at the wrap,
    // including the very first cycle after reset.
    always_comb begin
        r_cur    = (phase_q == '0) ? interp_ratio : ratio_q;
        r_eff    = cic_ratio_eff(r_cur);
        ratio_d  = r_cur;
        phase_d  = (phase_q >= r_eff - CIC_RATIO_W'(1)) ? '0 : phase_q + CIC_RATIO_W'(1);
        in_ready = ~rst & (phase_q == '0);
        consume  = in_ready;
        underrun = in_ready & ~in_valid;
        sample   = in_valid ? d_in : '0;
        sample_ext = {{(WIDTH-CIC_SAMPLE_W){sample[CIC_SAMPLE_W-1]}}, sample};
    end

    // Each stage keeps its own delay so the chain has no self-referencing vector.
    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        logic [WIDTH-1:0] x, y, dly_q, dly_d;
        if (k == 0) begin : g_in
            assign x = sample_ext;
        end else begin : g_chain
            assign x = g_comb[k-1].y;
        end
        always_comb begin
            y     = x - dly_q;
            dly_d = consume ? x : dly_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) dly_q <= '0;
            else     dly_q <= dly_d;
        end
    end

    always_comb begin
        comb_out_d = consume ? g_comb[ORDER-1].y : comb_out_q;
        stuff_d    = consume;
        integ_in   = stuff_q ? comb_out_q : '0;
        integ_d[0] = integ_q[0] + integ_in;
        for (int k = 1; k < ORDER; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        // Sticky start bit rides down the pipe to line up with the first real output.
        vld_pipe_d = {vld_pipe_q[ORDER:0], vld_pipe_q[0] | consume};
        d_out_d    = sat_out;
    end

    cic_sat #(.WIDTH(WIDTH)) u_sat (
        .din   (integ_q[ORDER-1]),
        .shift (out_shift),
        .dout  (sat_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= '0;
            ratio_q    <= '0;
            comb_out_q <= '0;
            stuff_q    <= 1'b0;
            integ_q    <= '0;
            vld_pipe_q <= '0;
            d_out_q    <= '0;
        end else begin
            phase_q    <= phase_d;
            ratio_q    <= ratio_d;
            comb_out_q <= comb_out_d;
            stuff_q    <= stuff_d;
            integ_q    <= integ_d;
            vld_pipe_q <= vld_pipe_d;
            d_out_q    <= d_out_d;
        end
    end

    assign d_out     = d_out_q;
    assign out_valid = vld_pipe_q[ORDER+1];

endmodule

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp: impulse, DC, underrun, saturation, reset, ratio change.
module tb_cic_interp;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] interp_ratio;
    logic [5:0]  out_shift;
    logic [7:0]  d_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  d_out;
    logic        out_valid;
    logic        underrun;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cic_interp #(.WIDTH(41), .ORDER(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .interp_ratio (interp_ratio),
        .out_shift    (out_shift),
        .d_in         (d_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .d_out        (d_out),
        .out_valid    (out_valid),
        .underrun     (underrun)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Holds reset for two cycles, checks the cleared state, releases just after a negedge.
    task automatic apply_reset(input int r, input int sh);
        rst          = 1'b1;
        in_valid     = 1'b0;
        d_in         = 8'd0;
        interp_ratio = 16'(r);
        out_shift    = 6'(sh);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_d_out", $signed(d_out), 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_underrun", underrun, 0);
        rst = 1'b0;
    endtask

    int imp_exp [17];
    int found;

    initial begin
        rst = 1'b1; interp_ratio = 16'd2; out_shift = 6'd0; d_in = 8'd0; in_valid = 1'b0;

        // Impulse, R=2: taps of (1+z^-1)^5 appear 7 cycles after consumption.
        for (int k = 0; k < 17; k++) imp_exp[k] = 0;
        imp_exp[7] = 1; imp_exp[8] = 5; imp_exp[9] = 10;
        imp_exp[10] = 10; imp_exp[11] = 5; imp_exp[12] = 1;
        apply_reset(2, 0);
        d_in = 8'd1; in_valid = 1'b1;
        #1;
        chk("imp_in_ready0", in_ready, 1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) d_in = 8'd0;
            #1;
            chk($sformatf("imp_d_out[%0d]", k), $signed(d_out), imp_exp[k]);
            if (k == 6 || k == 7)
                chk($sformatf("imp_out_valid[%0d]", k), out_valid, (k == 7) ? 1 : 0);
        end

        // DC, R=4, shift 8: gain 4^4 = 256 so a constant 1 settles at 1.
        apply_reset(4, 8);
        d_in = 8'd1; in_valid = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("dc_d_out", $signed(d_out), 1);
            chk("dc_out_valid", out_valid, 1);
            @(negedge clk);
            #1;
        end

        // Underrun: one missed slot injects a zero; every output it touches
        // (16 taps, each < 256) drops to 0 after the shift.
        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            if (in_ready) found = 1;
            else begin @(negedge clk); #1; end
        end
        chk("ur_found_slot", found, 1);
        in_valid = 1'b0;
        #1;
        for (int j = 0; j < 24; j++) begin
            if (j > 0) begin
                @(negedge clk);
                if (j == 1) in_valid = 1'b1;
                #1;
            end
            chk($sformatf("ur_in_ready[%0d]", j), in_ready, (j % 4 == 0) ? 1 : 0);
            chk($sformatf("ur_underrun[%0d]", j), underrun, (j == 0) ? 1 : 0);
            chk($sformatf("ur_d_out[%0d]", j), $signed(d_out), (j >= 7 && j <= 22) ? 0 : 1);
        end

        // Saturation, R=4, shift 0.
        apply_reset(4, 0);
        d_in = 8'd127; in_valid = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("sat_pos_a", $signed(d_out), 127);
        @(negedge clk); #1;
        chk("sat_pos_b", $signed(d_out), 127);
        d_in = 8'h80;
        repeat (60) @(negedge clk);
        #1;
        chk("sat_neg_a", $signed(d_out), -128);
        @(negedge clk); #1;
        chk("sat_neg_b", $signed(d_out), -128);
        chk("sat_out_valid", out_valid, 1);

        // Mid-stream reset: outputs clear asynchronously, old state is discarded.
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_d_out", $signed(d_out), 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_underrun", underrun, 0);
        @(negedge clk);
        rst = 1'b0; interp_ratio = 16'd4; d_in = 8'd5; in_valid = 1'b1;
        #1;
        chk("mrst_in_ready_rel", in_ready, 1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mrst_out_valid[%0d]", k), out_valid, (k == 7) ? 1 : 0);
            chk($sformatf("mrst_d_out[%0d]", k), $signed(d_out), (k == 7) ? 5 : 0);
        end

        // Ratio 4 -> 8 written at phase 2: next slot still 4 after, then 8.
        apply_reset(4, 0);
        d_in = 8'd0; in_valid = 1'b1;
        #1;
        for (int n = 0; n <= 24; n++) begin
            if (n > 0) begin
                @(negedge clk);
                if (n == 10) interp_ratio = 16'd8;
                #1;
            end
            chk($sformatf("ratio_in_ready[%0d]", n), in_ready,
                (n < 10) ? ((n % 4 == 0) ? 1 : 0) : ((n == 12 || n == 20) ? 1 : 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cic_interp.md
CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 SHALL have parameter WIDTH, default 41, internal comb/integrator datapath width in bits.
REQ-002 SHALL have parameter ORDER, default 5, number of comb stages and number of integrator stages.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port interp_ratio  input  16  interpolation ratio R, unsigned.
REQ-006 SHALL have port out_shift  input  6  arithmetic right-shift applied before output saturation.
REQ-007 SHALL have port d_in  input  8  signed input sample.
REQ-008 SHALL have port in_valid  input  1  d_in holds a sample.
REQ-009 SHALL have port in_ready  output  1  block accepts d_in this cycle.
REQ-010 SHALL have port d_out  output  8  signed output sample, one per clk.
REQ-011 SHALL have port out_valid  output  1  d_out is meaningful.
REQ-012 SHALL have port underrun  output  1  single-cycle pulse: sample slot missed.

Function
REQ-013 SHALL keep a 16-bit phase counter counting 0..R-1 and wrapping to 0; R of 0 or 1 SHALL be treated as 1, with phase held at 0.
REQ-014 SHALL sample interp_ratio only when phase wraps to 0; mid-period changes SHALL take effect at the next wrap.
REQ-015 SHALL drive in_ready high exactly when phase==0 and not in reset.
REQ-016 SHALL consume d_in when in_ready and in_valid; when in_ready and not in_valid, SHALL consume a zero sample and pulse underrun for that cycle.
REQ-017 On each consumption, SHALL sign-extend the sample to WIDTH, pass it through ORDER cascaded differentiators (y = x - x_prev, delay 1 input sample each, 2's-complement wraparound) and register the result in comb_out.
REQ-018 SHALL zero-stuff: the integrator input in the cycle after a consumption SHALL be comb_out; in all other cycles it SHALL be 0.
REQ-019 SHALL run ORDER registered integrators every clk (i_k <= i_k + i_{k-1}), with WIDTH-bit wraparound and no saturation.
REQ-020 SHALL compute d_out <= saturate_8(i_ORDER >>> out_shift), clamping to [-128, 127].
REQ-021 Latency SHALL be ORDER+2 clk from the consumption cycle to the first d_out affected by that sample (7 for ORDER=5).
REQ-022 SHALL assert out_valid from ORDER+2 cycles after the first consumption following reset, and keep it high until the next reset.
REQ-023 DC gain SHALL be R^(ORDER-1) before shifting; the user SHALL keep 8 + ORDER*log2(R) <= WIDTH.

Reset
REQ-024 While rst is high, SHALL clear phase, comb delays, comb_out, integrators, d_out, out_valid, underrun and in_ready to 0, asynchronously.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight samples; after release, phase restarts at 0 and interp_ratio is sampled in the first cycle.

Structure
REQ-026 SHALL take CIC_WIDTH=41 and CIC_ORDER=5 defaults and the 8-bit sample width constant from shared package cic_pkg, which the decimator also uses.
REQ-027 SHALL place shift-and-saturate in one sub-module, cic_sat (WIDTH-bit input, shift, 8-bit saturated output), shared with the decimator.

Verification
REQ-028 Impulse: ORDER=5, R=2, out_shift=0, d_in=1 then 0 with in_valid held high -> d_out sequence 1,5,10,10,5,1 starting at latency 7, then 0.
REQ-029 DC: R=4, out_shift=8, d_in=1 constant -> d_out settles to 1 and stays at 1.
REQ-030 Saturation: R=4, out_shift=0, d_in=127 constant -> d_out settles at 127; d_in=-128 -> d_out settles at -128.
REQ-031 Handshake/underrun: R=4, in_valid low at one phase-0 slot -> in_ready high 1 cycle in 4, underrun pulses exactly once, and a zero is inserted.
REQ-032 Ratio change and reset: R changes 4->8 mid-period, in_ready spacing changes only after the wrap; rst pulsed mid-stream -> all outputs 0 immediately and out_valid low until 7 cycles after the next consumption.
